spi_sample_rx: RTL and testbench
================================

// Module: spi_sample_rx
// PURPOSE
//  SPI slave receiver for the 11-bit sign-magnitude sample frames our FPGA SPI master emits toward the Pi.
//  Oversamples sclk/ncs/din on the 40 MHz system clock, assembles MSB-first frames and queues them in a small FIFO.
//  Presents each frame on a valid/ready interface in sign-magnitude and two's-complement form.
//  Used as the loopback/second-board input path feeding the effects datapath.
// PARAMETERS
//  FRAME_BITS   11  bits per frame: [FRAME_BITS-1]=sign, rest=magnitude
//  FIFO_DEPTH   4   queued frames; power of two, >=2
//  SYNC_STAGES  2   flip-flops per input synchronizer, >=2
// PORTS
//  clk         in   1             system clock (40 MHz, >=16x sclk)
//  reset       in   1             asynchronous, active-high
//  sclk_in     in   1             SPI clock from master, idle low, async to clk
//  ncs_in      in   1             SPI chip select, active low, async
//  din_in      in   1             SPI data; master changes on sclk fall, we sample on sclk rise
//  out_ready   in   1             consumer accepts head frame when out_valid&&out_ready
//  out_valid   out  1             FIFO non-empty
//  out_sm      out  FRAME_BITS    head frame, sign-magnitude, as received
//  out_tc      out  FRAME_BITS+1  head frame, two's complement
//  frame_err   out  1             1-cycle pulse: short or long frame
//  overflow    out  1             1-cycle pulse: complete frame dropped, FIFO full
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  frames queued
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, shift reg/bit count 0, FSM=WAIT_IDLE.
//  Inputs pass SYNC_STAGES-FF synchronizers; edges detected against one further registered copy.
//  FSM:
//   WAIT_IDLE: ignore everything until synced ncs==1 -> IDLE (prevents partial frame after reset mid-frame).
//   IDLE: ncs falling edge -> SHIFT, bit count=0, shift reg=0.
//   SHIFT: each sclk rising edge: shift reg={shift reg,din}, count+1. When count reaches FRAME_BITS the frame commits
//     (push to FIFO) in the next clk, FSM -> HOLD. ncs rise with count<FRAME_BITS -> frame_err pulse, discard, IDLE.
//   HOLD: sclk rising edges are excess; first one pulses frame_err once per frame (frame stays committed). ncs rise -> IDLE.
//  sclk edges while ncs high are ignored. ncs rise and sclk rise in the same clk: ncs wins (edge ignored).
//  Latency: final sclk rise at pin -> out_valid high (FIFO previously empty) = SYNC_STAGES+2 clk (4 by default).
//  FIFO: push on commit; pop on out_valid&&out_ready. Push while full without pop -> frame dropped, overflow pulse,
//   contents unchanged. Push+pop same cycle while full -> both happen, count unchanged. Pop while empty: no effect.
//   Pointers wrap modulo FIFO_DEPTH; fifo_count saturates nowhere (0..FIFO_DEPTH exact).
//  out_sm/out_tc are combinational from the FIFO head; hold value while out_valid&&!out_ready; don't-care when empty.
//  out_tc = sign ? -{2'b0,mag} : {2'b0,mag}, width FRAME_BITS+1; negative zero (sign=1,mag=0) -> 0.
//  Reset asserted mid-frame: partial frame discarded, FIFO flushed, FSM restarts in WAIT_IDLE.
// STRUCTURE
//  spi_pkg (shared): SAMPLE_BITS=11 constant; typedef struct packed {logic sign; logic [9:0] mag;} sample_sm_t;
//   function sm_to_tc(sample_sm_t) -> logic [11:0]; typedef enum {WAIT_IDLE,IDLE,SHIFT,HOLD} spi_rx_state_t.
//  Sub-module sample_fifo (parameterised width/depth, synchronous, count output, push-when-full-with-pop rule).
//  Top: synchronizers, edge detect, FSM, shift register, sm->tc conversion.
// TESTING
//  1 Frame 11'b0_0001010101 at 625 kHz, out_ready=1 -> out_valid 1 cycle, out_sm=11'h055, out_tc=12'h055, 4 clk after last sclk rise.
//  2 Frame 11'b1_0000000011 -> out_tc=12'hFFD; frame 11'b1_0000000000 -> out_tc=12'h000.
//  3 out_ready=0, send 5 frames (values 1..5) -> fifo_count 4, one overflow pulse on 5th; draining yields 1,2,3,4.
//  4 ncs rises after 6 bits -> frame_err pulse, nothing queued; next full frame 11'h3FF received correctly.
//  5 13 sclk pulses in one ncs window -> first 11 bits queued, exactly one frame_err pulse.
//  6 Assert reset after 5 bits with ncs low, release, finish that transfer -> nothing queued; next frame received normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI sample path: frame layout, receiver states and
// the sign-magnitude to two's-complement conversion.
package spi_pkg;

  localparam int SAMPLE_BITS = 11;

  typedef struct packed {
    logic                   sign;
    logic [SAMPLE_BITS-2:0] mag;
  } sample_sm_t;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    HOLD      = 2'd3
  } spi_rx_state_t;

  // Negating a zero magnitude yields zero, so negative zero folds to 0.
  function automatic logic [SAMPLE_BITS:0] sm_to_tc(input sample_sm_t s);
    logic [SAMPLE_BITS:0] m;
    m = {2'b00, s.mag};
    return s.sign ? (~m + 1'b1) : m;
  endfunction

endpackage

// File: rtl/spi_sample_rx_fifo.sv
// Small synchronous frame FIFO with occupancy count and a registered
// overflow pulse; a push into a full FIFO succeeds only alongside a pop.
module sample_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      count_q;
  logic             overflow_q;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
      overflow_q <= push_i && !do_push;
    end
  end

  assign data_o     = mem_q[rd_q];
  assign valid_o    = !empty;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/spi_sample_rx.sv
// SPI slave receiver: oversampled sclk/ncs/din, MSB-first frame assembly,
// frame FIFO and sign-magnitude / two's-complement presentation.
module spi_sample_rx
  import spi_pkg::*;
#(
  parameter int FRAME_BITS  = SAMPLE_BITS,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sclk_in,
  input  logic                          ncs_in,
  input  logic                          din_in,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [FRAME_BITS-1:0]         out_sm,
  output logic [FRAME_BITS:0]           out_tc,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output spi_rx_state_t                 dbg_state_o
);

  // Handshake: a frame leaves the FIFO on a clk edge where out_valid && out_ready;
  // out_sm/out_tc are held stable while out_valid && !out_ready.

  localparam int CW = $clog2(FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   sclk_prev_q;
  logic                   ncs_prev_q;
  logic                   sclk_s;
  logic                   ncs_s;
  logic                   din_s;
  logic                   sclk_rise;
  logic                   ncs_rise;
  logic                   ncs_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '0;
      din_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs_in};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din_in};
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];
  // sclk edges only count while chip select is low; an ncs rise therefore beats a coincident sclk rise.
  assign sclk_rise = sclk_s && !sclk_prev_q && !ncs_s;
  assign ncs_rise  = ncs_s && !ncs_prev_q;
  assign ncs_fall  = !ncs_s && ncs_prev_q;

  spi_rx_state_t         state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  err_seen_q, err_seen_d;
  logic                  frame_err_q, frame_err_d;
  logic                  push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      err_seen_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      err_seen_q  <= err_seen_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    err_seen_d  = err_seen_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      WAIT_IDLE: if (ncs_s) state_d = IDLE;
      IDLE: begin
        if (ncs_fall) begin
          state_d    = SHIFT;
          cnt_d      = '0;
          shift_d    = '0;
          err_seen_d = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(FRAME_BITS)) begin
          push = 1'b1;
          if (ncs_rise) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            if (sclk_rise) begin
              frame_err_d = 1'b1;
              err_seen_d  = 1'b1;
            end
          end
        end else if (ncs_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], din_s};
          cnt_d   = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (ncs_rise) begin
          state_d = IDLE;
        end else if (sclk_rise && !err_seen_q) begin
          frame_err_d = 1'b1;
          err_seen_d  = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  sample_fifo #(
    .WIDTH (FRAME_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .data_i     (shift_q),
    .pop_i      (out_ready),
    .data_o     (out_sm),
    .valid_o    (out_valid),
    .count_o    (fifo_count),
    .overflow_o (overflow)
  );

  generate
    if (FRAME_BITS == SAMPLE_BITS) begin : g_tc_pkg
      assign out_tc = sm_to_tc(sample_sm_t'(out_sm));
    end else begin : g_tc_generic
      logic [FRAME_BITS:0] mag_ext;
      assign mag_ext = {2'b00, out_sm[FRAME_BITS-2:0]};
      assign out_tc  = out_sm[FRAME_BITS-1] ? (~mag_ext + 1'b1) : mag_ext;
    end
  endgenerate

  assign frame_err   = frame_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_sample_rx.sv
// Self-checking bench for spi_sample_rx: SPI master driver tasks, a
// queue-based scoreboard fed at stimulus time, and a decoupled output monitor.
module tb_spi_sample_rx;
  import spi_pkg::*;

  localparam int DEPTH = 4;

  logic                  clk;
  logic                  reset;
  logic                  sclk_in;
  logic                  ncs_in;
  logic                  din_in;
  logic                  out_ready;
  logic                  out_valid;
  logic [10:0]           out_sm;
  logic [11:0]           out_tc;
  logic                  frame_err;
  logic                  overflow;
  logic [2:0]            fifo_count;
  spi_rx_state_t         dbg_state;

  spi_sample_rx dut (
    .clk         (clk),
    .reset       (reset),
    .sclk_in     (sclk_in),
    .ncs_in      (ncs_in),
    .din_in      (din_in),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_sm      (out_sm),
    .out_tc      (out_tc),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .fifo_count  (fifo_count),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [10:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int exp_err = 0;
  int exp_ovf = 0;
  int err_seen = 0;
  int ovf_seen = 0;
  int ready_mode = 1;
  int last_rise_cyc = 0;
  int valid_rise_cyc = 0;
  logic valid_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Two's complement of a sign-magnitude frame, by plain integer arithmetic.
  function automatic logic [11:0] model_tc(input logic [10:0] f);
    int m;
    int v;
    m = int'(f[9:0]);
    v = f[10] ? -m : m;
    return v[11:0];
  endfunction

  // A complete frame lands in the FIFO unless the consumer is stalled and it already holds DEPTH frames.
  task automatic expect_frame(input logic [10:0] f);
    if (ready_mode == 0 && exp_q.size() >= DEPTH) exp_ovf++;
    else exp_q.push_back(f);
  endtask

  task automatic check_sb(input string tag);
    check({tag, " drained"}, exp_q.size(), 0);
    check({tag, " frame_err count"}, err_seen, exp_err);
    check({tag, " overflow count"}, ovf_seen, exp_ovf);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      valid_prev = 1'b0;
    end else begin
      if (frame_err) err_seen++;
      if (overflow) ovf_seen++;
      if (out_valid && !valid_prev) valid_rise_cyc = cyc;
      valid_prev = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected frame", {21'b0, out_sm}, 32'hFFFF_FFFF);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          check("out_sm", {21'b0, out_sm}, {21'b0, e});
          check("out_tc", {20'b0, out_tc}, {20'b0, model_tc(e)});
        end
      end
    end
  end

  // ---------------- consumer ready driver ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- SPI master driver ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, input int half);
    din_in = b;
    wait_clk(half);
    sclk_in = 1'b1;
    last_rise_cyc = cyc;
    wait_clk(half);
    sclk_in = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] data, input int nbits, input int half);
    logic [31:0] d;
    d = data;
    ncs_in = 1'b0;
    wait_clk(half);
    for (int i = nbits - 1; i >= 0; i--) clock_bit(d[i], half);
    wait_clk(half);
    ncs_in = 1'b1;
    wait_clk(2 * half);
  endtask

  task automatic send_frame(input logic [10:0] f, input int half);
    expect_frame(f);
    send_bits({21'b0, f}, 11, half);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [12:0] long_f;
    logic [10:0] rv;
    reset   = 1'b1;
    sclk_in = 1'b0;
    ncs_in  = 1'b1;
    din_in  = 1'b0;
    wait_clk(5);
    check("reset out_valid", out_valid, 0);
    check("reset fifo_count", fifo_count, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overflow", overflow, 0);
    check("reset out_sm", out_sm, 0);
    check("reset out_tc", out_tc, 0);
    check("reset state", dbg_state, WAIT_IDLE);
    reset = 1'b0;
    wait_clk(10);
    check("idle after ncs high", dbg_state, IDLE);

    // Basic frame at 625 kHz and its latency from the last sclk rise.
    ready_mode = 1;
    send_frame(11'h055, 32);
    wait_clk(20);
    check("latency", valid_rise_cyc - last_rise_cyc, 4);
    check_sb("t1");

    // Negative value and negative zero.
    send_frame(11'h403, 10);
    send_frame(11'h400, 10);
    wait_clk(20);
    check_sb("t2");

    // Stalled consumer: four frames queue, the fifth overflows.
    ready_mode = 0;
    wait_clk(3);
    for (int v = 1; v <= 5; v++) send_frame(11'(v), 8);
    wait_clk(20);
    check("stall fifo_count", fifo_count, DEPTH);
    check("stall head held", out_sm, 1);
    check("stall out_valid", out_valid, 1);
    ready_mode = 1;
    wait_clk(20);
    check("drained fifo_count", fifo_count, 0);
    check_sb("t3");

    // Short frame, then a full-scale frame.
    send_bits(32'h2D, 6, 10);
    exp_err++;
    send_frame(11'h3FF, 10);
    wait_clk(20);
    check_sb("t4");

    // Long frame: 13 clocks, first 11 bits kept, one error pulse.
    long_f = 13'($urandom);
    expect_frame(long_f[12:2]);
    exp_err++;
    send_bits({19'b0, long_f}, 13, 9);
    wait_clk(20);
    check_sb("t5");

    // Reset in the middle of a transfer; the remainder must be ignored.
    ncs_in = 1'b0;
    wait_clk(10);
    for (int i = 0; i < 5; i++) clock_bit(1'($urandom), 10);
    #2 reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) clock_bit(1'($urandom), 10);
    wait_clk(10);
    ncs_in = 1'b1;
    wait_clk(20);
    check("reset-mid fifo_count", fifo_count, 0);
    check("reset-mid state", dbg_state, IDLE);
    rv = 11'($urandom);
    send_frame(rv, 10);
    wait_clk(20);
    check_sb("t6");

    // Randomized frames, rates and consumer backpressure.
    ready_mode = 2;
    for (int n = 0; n < 20; n++) begin
      rv = 11'($urandom);
      send_frame(rv, $urandom_range(8, 20));
    end
    ready_mode = 1;
    wait_clk(30);
    check_sb("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
